// File: rtl/alu_ex_pkg.sv
// rtl/alu_ex_pkg.sv - shared ALUop codes, FSM encoding and width default for the execute stage
package alu_ex_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Overflow/CarryOut only carry meaning for the adder paths.
    function automatic logic has_arith_flags(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: logic ops, add/sub with flags, signed/unsigned set-less-than
module alu
    import alu_ex_pkg::*;
#(
    parameter int DATA_WIDTH = alu_ex_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    // The extra top bit of diff is the borrow, i.e. A < B unsigned.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_XOR:  Result = A ^ B;
            OP_NOR:  Result = ~(A | B);
            OP_ADD: begin
                Result   = sum[MSB:0];
                CarryOut = sum[DATA_WIDTH];
                Overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                Result   = diff[MSB:0];
                CarryOut = diff[DATA_WIDTH];
                Overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_SLTU: Result = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:  Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
    end

    assign Zero = ~|Result;

endmodule

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - execute-stage sequencer around alu: request latch, EXEC, held response
// Optional saturating op/overflow counters under ALU_EX_STATS_EN.
module alu_ex_stage
    import alu_ex_pkg::*;
#(
    parameter int DATA_WIDTH = alu_ex_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero,
    output logic                  resp_overflow,
    output logic                  resp_carryout
`ifdef ALU_EX_STATS_EN
    ,
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_ovf
`endif
);

    state_e                state_q, state_d;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q, ovf_q, co_q;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero, alu_ovf, alu_co;
    logic                  req_hs, resp_hs;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .A        (a_q),
        .B        (b_q),
        .ALUop    (op_q),
        .Overflow (alu_ovf),
        .CarryOut (alu_co),
        .Zero     (alu_zero),
        .Result   (alu_result)
    );

    assign req_hs  = req_valid && (state_q == ST_IDLE);
    assign resp_hs = resp_ready && (state_q == ST_RESP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            co_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                ovf_q    <= alu_ovf && has_arith_flags(op_q);
                co_q     <= alu_co && has_arith_flags(op_q);
            end
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_result   = result_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = ovf_q;
    assign resp_carryout = co_q;

`ifdef ALU_EX_STATS_EN
    logic [31:0] stat_ops_q, stat_ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops_q <= 32'd0;
            stat_ovf_q <= 32'd0;
        end else if (resp_hs) begin
            if (stat_ops_q != 32'hFFFF_FFFF) stat_ops_q <= stat_ops_q + 32'd1;
            if (ovf_q && (stat_ovf_q != 32'hFFFF_FFFF)) stat_ovf_q <= stat_ovf_q + 32'd1;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule
